bip_core: RTL and testbench

Single-cycle accumulator CPU core (BIP class) made of three cooperating units: a control unit (PC, instruction decode), a datapath (accumulator, adder/subtractor, operand muxes) and a 2048×16 data RAM. It fetches 16-bit instructions from an external asynchronous-read program ROM addressed by `PC`. Every executed instruction retires in one clock. It is the CPU block of the BIP top level.

---
 rtl/bip_core.sv | 154 +++++++++++++++
 tb/tb_bip_core.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bip_core.sv
// BIP-class single-cycle accumulator CPU: control unit, datapath and 2^ADDR_WIDTH x DATA_WIDTH data RAM.
// Instructions come from an external combinational ROM addressed by PC; every instruction retires in one clock.

module bip_ctrl #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [15:0]           INSTRUCTION,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [ADDR_WIDTH-1:0] operand,
    output logic [1:0]            sel_a,
    output logic                  sel_b,
    output logic                  op,
    output logic                  wr_acc,
    output logic                  wr_ram,
    output logic                  rd_ram,
    output logic                  halt
);
    logic [4:0] opcode;

    assign opcode  = INSTRUCTION[15:11];
    assign operand = INSTRUCTION[ADDR_WIDTH-1:0];

    always_comb begin
        sel_a  = 2'd0;
        sel_b  = 1'b0;
        op     = 1'b0;
        wr_acc = 1'b0;
        wr_ram = 1'b0;
        rd_ram = 1'b0;
        halt   = 1'b0;
        case (opcode)
            5'b00000: halt = 1'b1;
            5'b00001: wr_ram = 1'b1;
            5'b00010: begin sel_a = 2'd0; wr_acc = 1'b1; rd_ram = 1'b1; end
            5'b00011: begin sel_a = 2'd1; wr_acc = 1'b1; end
            5'b00100: begin sel_a = 2'd2; sel_b = 1'b0; op = 1'b0; wr_acc = 1'b1; rd_ram = 1'b1; end
            5'b00101: begin sel_a = 2'd2; sel_b = 1'b1; op = 1'b0; wr_acc = 1'b1; end
            5'b00110: begin sel_a = 2'd2; sel_b = 1'b0; op = 1'b1; wr_acc = 1'b1; rd_ram = 1'b1; end
            5'b00111: begin sel_a = 2'd2; sel_b = 1'b1; op = 1'b1; wr_acc = 1'b1; end
            default: ;
        endcase
    end

    // HLT freezes PC, so the same HLT word keeps being fetched until reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            PC <= '0;
        else if (!halt)
            PC <= PC + ADDR_WIDTH'(1);
    end
endmodule

module bip_dp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] operand,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic [1:0]            sel_a,
    input  logic                  sel_b,
    input  logic                  op,
    input  logic                  wr_acc,
    output logic [DATA_WIDTH-1:0] ACC
);
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] opnd_b;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] acc_d;

    assign imm    = {{(DATA_WIDTH-ADDR_WIDTH){operand[ADDR_WIDTH-1]}}, operand};
    assign opnd_b = sel_b ? imm : ram_rdata;
    assign alu    = op ? ACC - opnd_b : ACC + opnd_b;

    always_comb begin
        acc_d = ram_rdata;
        case (sel_a)
            2'd1:    acc_d = imm;
            2'd2:    acc_d = alu;
            default: acc_d = ram_rdata;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            ACC <= '0;
        else if (wr_acc)
            ACC <= acc_d;
    end
endmodule

module bip_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wr,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    assign rdata = rd ? mem[addr] : '0;

    // Contents are deliberately not reset; reset only blocks writes.
    always_ff @(posedge CLK) begin
        if (RESET && wr)
            mem[addr] <= wdata;
    end
endmodule

module bip_core #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [15:0]           INSTRUCTION,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] ACC,
    output logic                  WR_ACC,
    output logic                  HALT
);
    logic [ADDR_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [1:0]            sel_a;
    logic                  sel_b;
    logic                  op;
    logic                  wr_ram;
    logic                  rd_ram;

    bip_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_ctrl (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .PC(PC), .operand(operand),
        .sel_a(sel_a), .sel_b(sel_b), .op(op), .wr_acc(WR_ACC), .wr_ram(wr_ram),
        .rd_ram(rd_ram), .halt(HALT)
    );

    bip_dp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_dp (
        .CLK(CLK), .RESET(RESET), .operand(operand), .ram_rdata(ram_rdata),
        .sel_a(sel_a), .sel_b(sel_b), .op(op), .wr_acc(WR_ACC), .ACC(ACC)
    );

    // STO writes the pre-edge ACC, which is exactly the register output here.
    bip_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .CLK(CLK), .RESET(RESET), .addr(operand), .wdata(ACC), .wr(wr_ram),
        .rd(rd_ram), .rdata(ram_rdata)
    );
endmodule

// File: tb/tb_bip_core.sv
// Self-checking bench for bip_core: ISA-level reference model, expected PC/ACC queued per step.
module tb_bip_core;
    localparam int DW = 16;
    localparam int AW = 11;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [15:0]   INSTRUCTION;
    logic [AW-1:0] PC;
    logic [DW-1:0] ACC;
    logic          WR_ACC;
    logic          HALT;

    logic [15:0]   rom [0:(1<<AW)-1];
    assign INSTRUCTION = rom[PC];

    bip_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
        .PC(PC), .ACC(ACC), .WR_ACC(WR_ACC), .HALT(HALT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] acc;
    } exp_t;

    exp_t          sbq[$];
    int            n_chk = 0;
    int            n_fail = 0;
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_acc;
    logic [DW-1:0] m_ram [0:(1<<AW)-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_decode(input string tag, input logic [15:0] ins);
        logic [4:0] opc;
        opc = ins[15:11];
        chk({tag, "_wr_acc"}, WR_ACC, (opc >= 5'd2 && opc <= 5'd7));
        chk({tag, "_halt"}, HALT, (opc == 5'd0));
    endtask

    // Called just after a falling edge; asserts reset between edges.
    task automatic do_reset(input int cycles);
        RESET = 1'b0;
        m_pc  = '0;
        m_acc = '0;
        #1;
        chk("rst_pc_async", PC, 0);
        chk("rst_acc_async", ACC, 0);
        repeat (cycles) begin
            @(posedge CLK);
            #1;
            chk("rst_pc_hold", PC, 0);
            chk("rst_acc_hold", ACC, 0);
            chk_decode("rst", rom[0]);
        end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic step();
        logic [15:0]   ins;
        logic [4:0]    opc;
        logic [AW-1:0] opd;
        logic [DW-1:0] imm;
        exp_t          e;
        ins = rom[m_pc];
        opc = ins[15:11];
        opd = ins[AW-1:0];
        imm = {{(DW-AW){opd[AW-1]}}, opd};
        #1;
        chk_decode("step", ins);
        case (opc)
            5'd1: m_ram[opd] = m_acc;
            5'd2: m_acc = m_ram[opd];
            5'd3: m_acc = imm;
            5'd4: m_acc = m_acc + m_ram[opd];
            5'd5: m_acc = m_acc + imm;
            5'd6: m_acc = m_acc - m_ram[opd];
            5'd7: m_acc = m_acc - imm;
            default: ;
        endcase
        if (opc != 5'd0) m_pc = m_pc + 1'b1;
        e.pc  = m_pc;
        e.acc = m_acc;
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        e = sbq.pop_front();
        chk("pc", PC, e.pc);
        chk("acc", ACC, e.acc);
        @(negedge CLK);
    endtask

    task automatic rom_fill_nop();
        for (int i = 0; i < (1 << AW); i++) rom[i] = 16'h4000;
    endtask

    logic [15:0] prog [12];
    logic [15:0] pexp [12];

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0;
        rom_fill_nop();
        @(negedge CLK);

        // Reset, NOP counting, PC wrap
        do_reset(3);
        repeat (3) step();
        chk("pc_after3", PC, 3);
        repeat (2044) step();
        chk("pc_2047", PC, 2047);
        step();
        chk("pc_wrap", PC, 0);

        // Immediate, sign extension, memory ops
        prog = '{16'h1805, 16'h2803, 16'h1FFF, 16'h2801, 16'h3801, 16'h1923,
                 16'h080A, 16'h1800, 16'h100A, 16'h200A, 16'h300A, 16'h3924};
        pexp = '{16'h0005, 16'h0008, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0123,
                 16'h0123, 16'h0000, 16'h0123, 16'h0246, 16'h0123, 16'hFFFF};
        rom_fill_nop();
        for (int i = 0; i < 12; i++) rom[i] = prog[i];
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("prog_acc", ACC, pexp[i]);
        end

        // Halt at address 4
        rom_fill_nop();
        rom[0] = 16'h1807;
        rom[1] = 16'h2801;
        rom[2] = 16'h4000;
        rom[3] = 16'h0814;
        rom[4] = 16'h0000;
        do_reset(1);
        repeat (4) step();
        chk("halt_pc_reach", PC, 4);
        repeat (5) step();
        chk("halt_pc_stay", PC, 4);
        chk("halt_acc", ACC, 16'h0008);
        chk("halt_flag", HALT, 1);
        chk("halt_wr_acc", WR_ACC, 0);

        // Mid-run reset; STO held in reset must not write
        rom_fill_nop();
        rom[0] = 16'h1855;
        rom[1] = 16'h081E;
        rom[2] = 16'h2801;
        do_reset(1);
        repeat (3) step();
        chk("mid_pc", PC, 3);
        chk("mid_acc", ACC, 16'h0056);
        rom[0] = 16'h081E;
        do_reset(2);
        rom[0] = 16'h101E;
        rom[1] = 16'h1014;
        step();
        chk("ram_kept", ACC, 16'h0055);
        step();
        chk("ram_sto_before_halt", ACC, 16'h0008);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
